// File: rtl/rv_wb_arb_pkg.sv
// Shared types for the writeback arbiter slice: register index, data word,
// and the grant decision encoding.
package rv_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LSU
    } grant_t;

endpackage

// File: rtl/rv_wb_arb_if.sv
// Writeback/issue bundle between the execution units and the arbiter.
// The master drives requests and issue info; the slave is the arbiter.
interface rv_wb_arb_if;
    import rv_pkg::*;

    logic     i_alu_valid;
    reg_idx_t i_alu_rd;
    word_t    i_alu_data;
    logic     o_alu_ready;

    logic     i_lsu_valid;
    reg_idx_t i_lsu_rd;
    word_t    i_lsu_data;
    logic     o_lsu_ready;

    logic     o_write;
    reg_idx_t o_rd;
    word_t    o_data;

    logic     i_issue;
    reg_idx_t i_issue_rd;
    reg_idx_t i_rs1;
    reg_idx_t i_rs2;
    logic     o_busy_rs1;
    logic     o_busy_rs2;

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        output o_alu_ready,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        output o_lsu_ready,
        output o_write, o_rd, o_data,
        input  i_issue, i_issue_rd, i_rs1, i_rs2,
        output o_busy_rs1, o_busy_rs2
    );

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        input  o_alu_ready,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  o_lsu_ready,
        input  o_write, o_rd, o_data,
        output i_issue, i_issue_rd, i_rs1, i_rs2,
        input  o_busy_rs1, o_busy_rs2
    );

endinterface

// File: rtl/rv_wb_arb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register x1..x31.
// x0 has no storage and always reads as not busy.
module rv_scoreboard
    import rv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     busy_rs1,
    output logic     busy_rs2
);

    logic [31:1] busy;
    logic [31:0] busy_vec;

    // A new issue to the same register outranks a writeback retiring it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (set_en && set_rd == reg_idx_t'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && clr_rd == reg_idx_t'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy_vec = {busy, 1'b0};
        busy_rs1 = busy_vec[rs1];
        busy_rs2 = busy_vec[rs2];
    end

endmodule

// File: rtl/rv_wb_arb.sv
// Register-file writeback arbiter: LSU priority with ALU starvation guard,
// one-cycle registered write port, and a pending-write scoreboard.
module rv_wb_arb
    import rv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
)
(
    input logic        i_clk,
    input logic        i_reset_n,
    rv_wb_arb_if.slave bus
);

    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    grant_t     grant;
    logic [1:0] starve_cnt;
    reg_idx_t   gnt_rd;
    word_t      gnt_data;

    // Grants are suppressed during reset so neither ready can rise.
    always_comb begin
        grant = GNT_NONE;
        if (i_reset_n) begin
            if (bus.i_alu_valid && bus.i_lsu_valid) begin
                grant = (starve_cnt == LIMIT) ? GNT_ALU : GNT_LSU;
            end else if (bus.i_alu_valid) begin
                grant = GNT_ALU;
            end else if (bus.i_lsu_valid) begin
                grant = GNT_LSU;
            end
        end
    end

    always_comb begin
        gnt_rd   = REG_ZERO;
        gnt_data = '0;
        case (grant)
            GNT_ALU: begin
                gnt_rd   = bus.i_alu_rd;
                gnt_data = bus.i_alu_data;
            end
            GNT_LSU: begin
                gnt_rd   = bus.i_lsu_rd;
                gnt_data = bus.i_lsu_data;
            end
            default: ;
        endcase
    end

    assign bus.o_alu_ready = (grant == GNT_ALU);
    assign bus.o_lsu_ready = (grant == GNT_LSU);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt <= '0;
        end else if (grant == GNT_ALU) begin
            starve_cnt <= '0;
        end else if (bus.i_alu_valid && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_write <= 1'b0;
            bus.o_rd    <= REG_ZERO;
            bus.o_data  <= '0;
        end else if (grant != GNT_NONE) begin
            bus.o_write <= (gnt_rd != REG_ZERO);
            bus.o_rd    <= gnt_rd;
            bus.o_data  <= gnt_data;
        end else begin
            bus.o_write <= 1'b0;
        end
    end

    rv_scoreboard u_scoreboard (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .set_en   (bus.i_issue && bus.i_issue_rd != REG_ZERO),
        .set_rd   (bus.i_issue_rd),
        .clr_en   (grant != GNT_NONE),
        .clr_rd   (gnt_rd),
        .rs1      (bus.i_rs1),
        .rs2      (bus.i_rs2),
        .busy_rs1 (bus.o_busy_rs1),
        .busy_rs2 (bus.o_busy_rs2)
    );

endmodule

// File: tb/tb_rv_wb_arb.sv
// Scoreboard bench for rv_wb_arb: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_rv_wb_arb;
    import rv_pkg::*;

    localparam int unsigned LIMIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rv_wb_arb_if bus();

    rv_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          w;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   busy_m[32];
    int   losses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model state is wiped the moment reset asserts.
    always @(negedge rst_n) begin
        exp_q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        losses = 0;
    end

    // Predictor: mid-cycle, decide who should win and what must be written.
    always @(negedge clk) begin
        bit   ga, gl;
        exp_t e;
        if (rst_n) begin
            ga = bus.i_alu_valid && (!bus.i_lsu_valid || losses >= int'(LIMIT));
            gl = bus.i_lsu_valid && !ga;
            check("alu_ready", 32'(bus.o_alu_ready), 32'(ga));
            check("lsu_ready", 32'(bus.o_lsu_ready), 32'(gl));
            check("busy_rs1", 32'(bus.o_busy_rs1), 32'(busy_m[bus.i_rs1]));
            check("busy_rs2", 32'(bus.o_busy_rs2), 32'(busy_m[bus.i_rs2]));
            e.rd   = 5'd0;
            e.data = 32'd0;
            if (ga) begin
                e.rd   = bus.i_alu_rd;
                e.data = bus.i_alu_data;
            end else if (gl) begin
                e.rd   = bus.i_lsu_rd;
                e.data = bus.i_lsu_data;
            end
            e.w = (ga || gl) && (e.rd != 5'd0);
            exp_q.push_back(e);
            if (ga || gl) busy_m[e.rd] = 1'b0;
            if (bus.i_issue && bus.i_issue_rd != 5'd0) busy_m[bus.i_issue_rd] = 1'b1;
            if (ga) losses = 0;
            else if (bus.i_alu_valid && losses < int'(LIMIT)) losses++;
        end
    end

    // Monitor: just after each edge, compare the registered write port.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            check("write_in_reset", 32'(bus.o_write), 32'd0);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.w = 1'b0; e.rd = 5'd0; e.data = 32'd0;
            end
            check("o_write", 32'(bus.o_write), 32'(e.w));
            if (e.w) begin
                check("o_rd", 32'(bus.o_rd), 32'(e.rd));
                check("o_data", bus.o_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.i_alu_valid = 1'b0; bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'd0;
        bus.i_lsu_valid = 1'b0; bus.i_lsu_rd = 5'd0; bus.i_lsu_data = 32'd0;
        bus.i_issue = 1'b0; bus.i_issue_rd = 5'd0;
        bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd0;
    endtask

    initial begin
        logic [4:0] pat;
        bit alu_acc, lsu_acc;
        pat     = 5'b01000;
        alu_acc = 1'b0;
        lsu_acc = 1'b0;

        // Reset state, with both requesters knocking.
        idle();
        bus.i_alu_valid = 1'b1;
        bus.i_lsu_valid = 1'b1;
        #2;
        check("rst_alu_ready", 32'(bus.o_alu_ready), 32'd0);
        check("rst_lsu_ready", 32'(bus.o_lsu_ready), 32'd0);
        check("rst_o_write", 32'(bus.o_write), 32'd0);
        check("rst_o_rd", 32'(bus.o_rd), 32'd0);
        check("rst_o_data", bus.o_data, 32'd0);
        idle();
        step();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // ALU alone, one-cycle write latency.
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'h1234_5678;
        #1;
        check("t031_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        step();
        check("t031_o_write", 32'(bus.o_write), 32'd1);
        check("t031_o_rd", 32'(bus.o_rd), 32'd5);
        check("t031_o_data", bus.o_data, 32'h1234_5678);
        idle();
        step();

        // Contention: LSU wins three times, then the starved ALU wins.
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd7; bus.i_alu_data = 32'hA0A0_0007;
        bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd6;
        for (int c = 0; c < 5; c++) begin
            bus.i_lsu_data = 32'hB000_0000 + 32'(c);
            #1;
            check("t032_alu_grant", 32'(bus.o_alu_ready), 32'(pat[c]));
            check("t032_lsu_grant", 32'(bus.o_lsu_ready), 32'(!pat[c]));
            step();
            if (c == 3) bus.i_alu_valid = 1'b0;
        end
        idle();
        step();

        // Busy set by issue, cleared by writeback, no same-cycle bypass.
        bus.i_issue = 1'b1; bus.i_issue_rd = 5'd9;
        step();
        idle();
        bus.i_rs1 = 5'd9;
        #1;
        check("t033_busy_set", 32'(bus.o_busy_rs1), 32'd1);
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd9; bus.i_alu_data = 32'h0000_0099;
        #1;
        check("t033_no_bypass", 32'(bus.o_busy_rs1), 32'd1);
        check("t033_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        step();
        bus.i_alu_valid = 1'b0;
        #1;
        check("t033_busy_clr", 32'(bus.o_busy_rs1), 32'd0);
        idle();
        step();

        // Same-cycle set and clear of x10: set wins.
        bus.i_issue = 1'b1; bus.i_issue_rd = 5'd10;
        bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd10; bus.i_lsu_data = 32'h0000_00AA;
        step();
        idle();
        bus.i_rs2 = 5'd10;
        #1;
        check("t034_set_wins", 32'(bus.o_busy_rs2), 32'd1);
        step();

        // x0: never busy, accepted, never written.
        idle();
        bus.i_issue = 1'b1; bus.i_issue_rd = 5'd0;
        step();
        idle();
        bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd0; bus.i_lsu_data = 32'hDEAD_BEEF;
        #1;
        check("t035_busy_x0", 32'(bus.o_busy_rs1), 32'd0);
        check("t035_lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
        step();
        idle();
        check("t035_no_write", 32'(bus.o_write), 32'd0);
        step();

        // Reset mid-flight: busy x3 pending, write in flight, counter saturated.
        bus.i_issue = 1'b1; bus.i_issue_rd = 5'd3;
        step();
        idle();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd4; bus.i_alu_data = 32'h0000_0044;
        bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd8; bus.i_lsu_data = 32'h0000_0088;
        for (int c = 0; c < 3; c++) step();
        bus.i_rs1 = 5'd3;
        #1;
        check("t036_pre_busy", 32'(bus.o_busy_rs1), 32'd1);
        check("t036_pre_alu_wins", 32'(bus.o_alu_ready), 32'd1);
        check("t036_pre_inflight", 32'(bus.o_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t036_write_cleared", 32'(bus.o_write), 32'd0);
        check("t036_busy_cleared", 32'(bus.o_busy_rs1), 32'd0);
        check("t036_alu_ready_rst", 32'(bus.o_alu_ready), 32'd0);
        check("t036_lsu_ready_rst", 32'(bus.o_lsu_ready), 32'd0);
        step();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("t036_lsu_after_rst", 32'(bus.o_lsu_ready), 32'd1);
        check("t036_alu_after_rst", 32'(bus.o_alu_ready), 32'd0);
        step();
        idle();

        // Random traffic honouring the hold-until-accepted rule.
        for (int n = 0; n < 1500; n++) begin
            if (!bus.i_alu_valid || alu_acc) begin
                bus.i_alu_valid = ($urandom_range(0, 99) < 55);
                bus.i_alu_rd    = 5'($urandom_range(0, 7));
                bus.i_alu_data  = $urandom;
            end
            if (!bus.i_lsu_valid || lsu_acc) begin
                bus.i_lsu_valid = ($urandom_range(0, 99) < 55);
                bus.i_lsu_rd    = 5'($urandom_range(0, 7));
                bus.i_lsu_data  = $urandom;
            end
            bus.i_issue    = ($urandom_range(0, 99) < 30);
            bus.i_issue_rd = 5'($urandom_range(0, 7));
            bus.i_rs1      = 5'($urandom_range(0, 7));
            bus.i_rs2      = 5'($urandom_range(0, 7));
            @(negedge clk);
            alu_acc = bus.o_alu_ready;
            lsu_acc = bus.o_lsu_ready;
            @(posedge clk);
            #2;
        end

        idle();
        for (int c = 0; c < 3; c++) step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
